decimal_entry: RTL and testbench
================================

# decimal_entry

Sequential decimal-to-binary entry block for the vending machine front panel, the input-side inverse of the binary-to-decimal seven-segment path. It collects single decimal digit strobes from the keypad logic into a right-justified BCD buffer. It supports backspace and clear. On enter it converts the buffered digits to a binary amount with an iterative multiply-by-ten accumulator and pulses a result-valid strobe to the vending controller.

## Interface
- DIGITS, 3, number of BCD digits held (entry range 0 to 10^DIGITS-1)
- WIDTH, 32, width of the binary result; must satisfy 2^WIDTH > 10^DIGITS-1
- i_clk  input  1  single clock, all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_digit  input  4  digit value, sampled only when i_digit_valid is high
- i_digit_valid  input  1  one-cycle strobe: append i_digit
- i_backspace  input  1  one-cycle strobe: drop the most recently entered digit
- i_clear  input  1  one-cycle strobe: empty the buffer
- i_enter  input  1  one-cycle strobe: start conversion
- o_digits  output  4*DIGITS  live BCD buffer; nibble 0 is the least significant and the newest digit
- o_count  output  $clog2(DIGITS+1)  number of digits currently buffered
- o_busy  output  1  high while conversion is in progress
- o_amount  output  WIDTH  last converted binary value; held until the next conversion completes
- o_valid  output  1  one-cycle pulse when o_amount is updated
- o_error  output  1  one-cycle pulse on a rejected digit (value >9 or buffer full)

## Operation
- States: IDLE and CONVERT.
- Reset (async, any time, including mid-conversion): state=IDLE, o_digits=0, o_count=0, o_busy=0, o_amount=0, o_valid=0, o_error=0.
  - A conversion in flight is abandoned with no o_valid pulse.
- IDLE: at most one action is taken per edge, priority i_clear > i_enter > i_backspace > i_digit_valid. Lower-priority strobes in the same cycle are dropped silently.
  - clear: o_digits=0, o_count=0.
  - enter: latch the buffer into the conversion shadow, acc=0, idx=DIGITS-1, go to CONVERT, o_busy=1. Enter with o_count=0 is legal and yields amount 0.
  - backspace with o_count>0: o_digits shifts right by one nibble with zero fill, o_count decrements. With o_count=0: no effect, no error.
  - digit with i_digit<=9 and o_count<DIGITS: o_digits shifts left by one nibble, i_digit enters nibble 0, o_count increments.
  - digit with i_digit>9, or with o_count==DIGITS: buffer unchanged, o_error=1 for one cycle.
- CONVERT: one nibble is processed per edge, from nibble idx=DIGITS-1 down to 0.
  - Update rule: acc = (acc<<3)+(acc<<1)+nibble[idx], computed in WIDTH bits.
  - Unused high nibbles are zero, so leading zeros do not change the result.
  - On the edge that processes idx=0: o_amount = the final acc value, o_valid=1, o_digits=0, o_count=0, o_busy=0, state=IDLE.
- All strobes are ignored while in CONVERT. Digits arriving in CONVERT do not raise o_error.
- o_valid and o_error are registered pulses, high for exactly one cycle.

## Timing
- Buffer edits (digit, backspace, clear): o_digits and o_count are updated on the same edge that samples the strobe. They are visible in the following cycle.
- Conversion latency is fixed and independent of o_count:
  - i_enter sampled at edge E.
  - o_busy is high for cycles E+1 through E+DIGITS.
  - o_valid and the new o_amount are visible in the cycle after edge E+DIGITS, which is 3 cycles for DIGITS=3.
- A new i_enter is accepted in the first IDLE cycle, i.e. the cycle in which o_valid is high. This gives back-to-back throughput of one conversion per DIGITS+1 cycles.
- No combinational path exists from any input to any output.

## Test plan
- Reset check: assert i_rst mid-cycle with no clock edge -> all outputs read 0 immediately. Release and enter digits 1,2,5 then enter -> o_digits=0x125, o_count=3, o_busy high 3 cycles, o_amount=125 with o_valid pulse, then buffer empties.
- Overflow and invalid digits: digits 9,9,9,4 -> 4th digit raises o_error, buffer stays 0x999. Enter -> o_amount=999. Digit 0xA on an empty buffer -> o_error, o_count stays 0.
- Backspace and clear: digits 7,3 then backspace -> 0x007, o_count=1. Backspace twice -> 0x000 and no error. Digits 4,2 then clear -> o_count=0. Enter -> o_amount=0 with o_valid.
- Simultaneous strobes: same cycle clear+enter+digit 5 with buffer 0x012 -> buffer cleared, no conversion. Same cycle enter+digit 5 with buffer 0x012 -> o_amount=12, and digit 5 is not retained.
- Busy lockout: during CONVERT, pulse digit 8, clear and enter -> no buffer change, no o_error, single o_valid. Then an immediate enter on the o_valid cycle is accepted.
- Reset mid-operation: enter with 0x456, assert i_rst on the 2nd busy cycle -> no o_valid, o_amount=0. After release, the block accepts new digits normally.

Source files
------------

// File: rtl/decimal_entry.sv
// decimal_entry: keypad digit collector with backspace/clear and an
// iterative BCD-to-binary converter (one nibble per clock, MSB first).
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_digit          digit value, used when i_digit_valid is high
//   i_digit_valid    append i_digit to the buffer
//   i_backspace      drop the newest digit
//   i_clear          empty the buffer
//   i_enter          start conversion of the buffered digits
//   o_digits         live BCD buffer, nibble 0 is the newest digit
//   o_count          number of buffered digits
//   o_busy           conversion in progress
//   o_amount         last converted binary value
//   o_valid          one-cycle pulse when o_amount updates
//   o_error          one-cycle pulse on a rejected digit
module decimal_entry #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned WIDTH  = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [3:0]                     i_digit,
    input  logic                           i_digit_valid,
    input  logic                           i_backspace,
    input  logic                           i_clear,
    input  logic                           i_enter,
    output logic [4*DIGITS-1:0]            o_digits,
    output logic [$clog2(DIGITS+1)-1:0]    o_count,
    output logic                           o_busy,
    output logic [WIDTH-1:0]               o_amount,
    output logic                           o_valid,
    output logic                           o_error
);

    localparam int unsigned BUF_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [BUF_W-1:0]   digits_q, digits_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               busy_q,   busy_d;
    logic [WIDTH-1:0]   amount_q, amount_d;
    logic               valid_q,  valid_d;
    logic               error_q,  error_d;
    logic [BUF_W-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;

    logic [3:0]         nibble;
    logic [WIDTH-1:0]   acc_next;

    // Current nibble of the conversion shadow and the acc*10+nibble step
    assign nibble   = 4'(shadow_q >> {idx_q, 2'b00});
    assign acc_next = (acc_q << 3) + (acc_q << 1) + WIDTH'(nibble);

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            amount_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            shadow_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            amount_q <= amount_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state: one buffer action per edge in IDLE, one nibble per edge in CONVERT
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        busy_d   = busy_q;
        amount_d = amount_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        idx_d    = idx_q;

        case (state_q)
            IDLE: begin
                if (i_clear) begin
                    digits_d = '0;
                    count_d  = '0;
                end else if (i_enter) begin
                    shadow_d = digits_q;
                    acc_d    = '0;
                    idx_d    = IDX_W'(DIGITS - 1);
                    busy_d   = 1'b1;
                    state_d  = CONVERT;
                end else if (i_backspace) begin
                    if (count_q != '0) begin
                        digits_d = digits_q >> 4;
                        count_d  = count_q - CNT_W'(1);
                    end
                end else if (i_digit_valid) begin
                    if (i_digit <= 4'd9 && count_q < CNT_W'(DIGITS)) begin
                        digits_d = (digits_q << 4) | BUF_W'(i_digit);
                        count_d  = count_q + CNT_W'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            CONVERT: begin
                if (idx_q == '0) begin
                    amount_d = acc_next;
                    valid_d  = 1'b1;
                    digits_d = '0;
                    count_d  = '0;
                    busy_d   = 1'b0;
                    acc_d    = '0;
                    state_d  = IDLE;
                end else begin
                    acc_d = acc_next;
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign o_digits = digits_q;
    assign o_count  = count_q;
    assign o_busy   = busy_q;
    assign o_amount = amount_q;
    assign o_valid  = valid_q;
    assign o_error  = error_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Testbench for decimal_entry (DIGITS=3, WIDTH=32): table of per-cycle
// vectors plus an amount scoreboard, and hand sequences for reset cases.
module tb_decimal_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        backspace;
    logic        clear;
    logic        enter;
    logic [11:0] digits;
    logic [1:0]  count;
    logic        busy;
    logic [31:0] amount;
    logic        valid;
    logic        error;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    decimal_entry #(.DIGITS(3), .WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_digit       (digit),
        .i_digit_valid (digit_valid),
        .i_backspace   (backspace),
        .i_clear       (clear),
        .i_enter       (enter),
        .o_digits      (digits),
        .o_count       (count),
        .o_busy        (busy),
        .o_amount      (amount),
        .o_valid       (valid),
        .o_error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        bit          ent;
        bit          bs;
        bit          dv;
        logic [3:0]  dig;
        logic [11:0] e_dig;
        logic [1:0]  e_cnt;
        bit          e_err;
        bit          e_busy;
        int          amt;   // -1: no conversion result expected from this vector
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit clr, bit ent, bit bs, bit dv, logic [3:0] dig,
                                logic [11:0] e_dig, logic [1:0] e_cnt,
                                bit e_err, bit e_busy, int amt);
        vec_t v;
        v.clr = clr; v.ent = ent; v.bs = bs; v.dv = dv; v.dig = dig;
        v.e_dig = e_dig; v.e_cnt = e_cnt; v.e_err = e_err; v.e_busy = e_busy;
        v.amt = amt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit clr, bit ent, bit bs, bit dv, logic [3:0] dig);
        clear = clr; enter = ent; backspace = bs; digit_valid = dv; digit = dig;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every o_valid pulse pops one expected amount
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 amount=%0d expected no pulse at %0t",
                         amount, $time);
            end else begin
                check("amount", amount, exp_q.pop_front());
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 4'd0);
        rst = 1'b1;
        #1;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_count",  32'(count),  32'h0);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_amount", amount,      32'h0);
        check("reset_valid",  32'(valid),  32'h0);
        check("reset_error",  32'(error),  32'h0);
        tick();
        tick();
        rst = 1'b0;

        // clr ent bs dv dig  e_dig   cnt err busy amt
        tbl.push_back(mk(0,0,0,1,4'd1, 12'h001,1,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd2, 12'h012,2,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd5, 12'h125,3,0,0,-1));
        tbl.push_back(mk(0,1,0,0,4'd0, 12'h125,3,0,1,125));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h125,3,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h125,3,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,0,-1));
        // overflow and invalid digit
        tbl.push_back(mk(0,0,0,1,4'd9, 12'h009,1,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd9, 12'h099,2,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd9, 12'h999,3,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd4, 12'h999,3,1,0,-1));
        tbl.push_back(mk(0,1,0,0,4'd0, 12'h999,3,0,1,999));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h999,3,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h999,3,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'hA, 12'h000,0,1,0,-1));
        // backspace and clear
        tbl.push_back(mk(0,0,0,1,4'd7, 12'h007,1,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd3, 12'h073,2,0,0,-1));
        tbl.push_back(mk(0,0,1,0,4'd0, 12'h007,1,0,0,-1));
        tbl.push_back(mk(0,0,1,0,4'd0, 12'h000,0,0,0,-1));
        tbl.push_back(mk(0,0,1,0,4'd0, 12'h000,0,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd4, 12'h004,1,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd2, 12'h042,2,0,0,-1));
        tbl.push_back(mk(1,0,0,0,4'd0, 12'h000,0,0,0,-1));
        tbl.push_back(mk(0,1,0,0,4'd0, 12'h000,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,0,-1));
        // simultaneous strobes
        tbl.push_back(mk(0,0,0,1,4'd1, 12'h001,1,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd2, 12'h012,2,0,0,-1));
        tbl.push_back(mk(1,1,0,1,4'd5, 12'h000,0,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd1, 12'h001,1,0,0,-1));
        tbl.push_back(mk(0,0,0,1,4'd2, 12'h012,2,0,0,-1));
        tbl.push_back(mk(0,1,0,1,4'd5, 12'h012,2,0,1,12));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h012,2,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h012,2,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,0,-1));
        // busy lockout, then enter on the o_valid cycle
        tbl.push_back(mk(0,0,0,1,4'd6, 12'h006,1,0,0,-1));
        tbl.push_back(mk(0,1,0,0,4'd0, 12'h006,1,0,1,6));
        tbl.push_back(mk(0,0,0,1,4'd8, 12'h006,1,0,1,-1));
        tbl.push_back(mk(1,0,0,0,4'd0, 12'h006,1,0,1,-1));
        tbl.push_back(mk(0,1,0,0,4'd0, 12'h000,0,0,0,-1));
        tbl.push_back(mk(0,1,0,0,4'd0, 12'h000,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,4'hF, 12'h000,0,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,1,-1));
        tbl.push_back(mk(0,0,0,0,4'd0, 12'h000,0,0,0,-1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].clr, tbl[i].ent, tbl[i].bs, tbl[i].dv, tbl[i].dig);
            if (tbl[i].amt >= 0) exp_q.push_back(32'(tbl[i].amt));
            tick();
            check($sformatf("v%0d_digits", i), 32'(digits), 32'(tbl[i].e_dig));
            check($sformatf("v%0d_count",  i), 32'(count),  32'(tbl[i].e_cnt));
            check($sformatf("v%0d_error",  i), 32'(error),  32'(tbl[i].e_err));
            check($sformatf("v%0d_busy",   i), 32'(busy),   32'(tbl[i].e_busy));
        end
        drive(0, 0, 0, 0, 4'd0);
        tick();
        check("results_drained", 32'(exp_q.size()), 32'd0);

        // Mid-cycle reset with no clock edge clears everything immediately
        drive(0, 0, 0, 1, 4'd4); tick();
        drive(0, 0, 0, 1, 4'd5); tick();
        drive(0, 0, 0, 0, 4'd0);
        check("pre_rst_digits", 32'(digits), 32'h045);
        #2 rst = 1'b1;
        #1;
        check("async_rst_digits", 32'(digits), 32'h0);
        check("async_rst_count",  32'(count),  32'h0);
        check("async_rst_amount", amount,      32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during the second busy cycle abandons the conversion
        drive(0, 0, 0, 1, 4'd4); @(posedge clk); #1;
        drive(0, 0, 0, 1, 4'd5); tick();
        drive(0, 0, 0, 1, 4'd6); tick();
        check("pre_conv_digits", 32'(digits), 32'h456);
        drive(0, 1, 0, 0, 4'd0); tick();
        drive(0, 0, 0, 0, 4'd0);
        check("conv_busy1", 32'(busy), 32'h1);
        tick();
        check("conv_busy2", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midconv_rst_busy",  32'(busy),  32'h0);
        check("midconv_rst_valid", 32'(valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        check("midconv_amount", amount, 32'h0);
        check("midconv_busy",   32'(busy), 32'h0);
        drive(0, 0, 0, 1, 4'd3); tick();
        drive(0, 0, 0, 0, 4'd0);
        check("post_rst_digits", 32'(digits), 32'h003);
        check("post_rst_count",  32'(count),  32'h1);
        check("post_rst_error",  32'(error),  32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
